pipe_stage_chain: RTL and testbench

//  Parametrised chain of pipeline stage registers with a central stall/flush controller.

---
 rtl/pipe_stage_chain_pkg.sv | 24 ++
 rtl/pipe_stage_chain_reg.sv | 56 +++++
 rtl/pipe_stage_chain.sv | 79 +++++++
 tb/tb_pipe_stage_chain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_chain_pkg.sv
// Shared defaults and types for the pipeline stage-register chain.
// Holds the stall-vector sizing helper and the per-register update actions.
package pipe_stage_chain_pkg;

  localparam int STAGES_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  // NOP is encoded as an all-zero payload; BUBBLE_VAL replicates this bit.
  localparam logic NOP_BIT = 1'b0;

  // One stall bit per pipeline stage S0..S_STAGES.
  function automatic int stall_w(input int stages);
    return stages + 1;
  endfunction

  typedef enum logic [1:0] {
    REG_LOAD   = 2'd0,
    REG_HOLD   = 2'd1,
    REG_BUBBLE = 2'd2,
    REG_FLUSH  = 2'd3
  } reg_action_e;

endpackage

// File: rtl/pipe_stage_chain_reg.sv
// One stage register Rk with flush, bubble insertion and stall hold.
// stall_up is the stall of the stage feeding this register, stall_dn the stage it feeds.
module pipe_stage_reg
  import pipe_stage_chain_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{NOP_BIT}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_up,
  input  logic              stall_dn,
  input  logic [DATA_W-1:0] d,
  input  logic              vld_in,
  output logic [DATA_W-1:0] q,
  output logic              vld
);

  reg_action_e action;

  // Flush wins over everything; a stalled producer feeding a running consumer
  // leaves a bubble behind so the consumer does not see the same payload twice.
  always_comb begin
    action = REG_HOLD;
    if (flush)
      action = REG_FLUSH;
    else if (stall_up && !stall_dn)
      action = REG_BUBBLE;
    else if (!stall_up)
      action = REG_LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= BUBBLE_VAL;
      vld <= 1'b0;
    end else begin
      unique case (action)
        REG_FLUSH, REG_BUBBLE: begin
          q   <= BUBBLE_VAL;
          vld <= 1'b0;
        end
        REG_LOAD: begin
          q   <= d;
          vld <= vld_in;
        end
        default: begin
          q   <= q;
          vld <= vld;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of STAGES pipeline registers with a central stall resolver and
// saturating stall/bubble performance counters.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int                STAGES     = STAGES_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{NOP_BIT}},
  parameter int                CNT_W      = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STAGES*DATA_W-1:0] stage_d_i,
  input  logic [STAGES-1:0]        stage_vld_i,
  input  logic [STAGES:0]          stall_req_i,
  input  logic [STAGES-1:0]        flush_i,
  input  logic                     cnt_clr_i,
  output logic [STAGES*DATA_W-1:0] stage_q_o,
  output logic [STAGES-1:0]        stage_vld_o,
  output logic [STAGES:0]          stall_o,
  output logic                     pc_hold_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         bubble_cnt_o
);

  localparam int STALL_W = stall_w(STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [STALL_W-1:0] stall_v;
  logic               any_bubble;

  // A stalling stage freezes itself and everything upstream: suffix OR from the top.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    stall_v = '0;
    for (int j = STALL_W - 1; j >= 0; j--) begin
      acc        = acc | stall_req_i[j];
      stall_v[j] = acc;
    end
  end

  assign stall_o    = stall_v;
  assign pc_hold_o  = stall_v[0];
  assign any_bubble = |(stall_v[STAGES-1:0] & ~stall_v[STAGES:1]);

  for (genvar k = 1; k <= STAGES; k++) begin : g_reg
    pipe_stage_reg #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_reg (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_i[k-1]),
      .stall_up (stall_v[k-1]),
      .stall_dn (stall_v[k]),
      .d        (stage_d_i[(k-1)*DATA_W +: DATA_W]),
      .vld_in   (stage_vld_i[k-1]),
      .q        (stage_q_o[(k-1)*DATA_W +: DATA_W]),
      .vld      (stage_vld_o[k-1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall_v[0] && stall_cnt_o != CNT_MAX)
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (any_bubble && bubble_cnt_o != CNT_MAX)
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: identity stage datapaths loop each Rk back into
// slice k, stall resolution is table-driven, stall/flush corners are hand sequences.
module tb_pipe_stage_chain;

  localparam int STAGES = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [STAGES*DATA_W-1:0] stage_d_i;
  logic [STAGES-1:0]        stage_vld_i;
  logic [STAGES:0]          stall_req_i;
  logic [STAGES-1:0]        flush_i;
  logic                     cnt_clr_i;
  logic [STAGES*DATA_W-1:0] stage_q_o;
  logic [STAGES-1:0]        stage_vld_o;
  logic [STAGES:0]          stall_o;
  logic                     pc_hold_o;
  logic [CNT_W-1:0]         stall_cnt_o;
  logic [CNT_W-1:0]         bubble_cnt_o;

  logic [DATA_W-1:0] d0;
  logic              v0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic [STAGES:0] req;
    logic [STAGES:0] exp_stall;
  } vec_t;
  vec_t vecs[10];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Each stage datapath is an identity function: slice k takes R(k) output.
  assign stage_d_i   = {stage_q_o[(STAGES-1)*DATA_W-1:0], d0};
  assign stage_vld_i = {stage_vld_o[STAGES-2:0], v0};

  pipe_stage_chain #(
    .STAGES (STAGES),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stage_d_i    (stage_d_i),
    .stage_vld_i  (stage_vld_i),
    .stall_req_i  (stall_req_i),
    .flush_i      (flush_i),
    .cnt_clr_i    (cnt_clr_i),
    .stage_q_o    (stage_q_o),
    .stage_vld_o  (stage_vld_o),
    .stall_o      (stall_o),
    .pc_hold_o    (pc_hold_o),
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rq(input int k);
    return stage_q_o[(k-1)*DATA_W +: DATA_W];
  endfunction

  task automatic feed(input logic [DATA_W-1:0] val, input logic vld);
    d0 = val;
    v0 = vld;
    tick();
  endtask

  // Scoreboard-checked free flow; fixed=1 feeds 0x11,0x22,0x33,0x44.
  task automatic run_flow(input int n, input bit fixed);
    logic [DATA_W-1:0] val;
    for (int i = 0; i < n + 8; i++) begin
      if (i < n) begin
        val = fixed ? DATA_W'(32'h11 * (i + 1)) : DATA_W'($urandom);
        d0 = val;
        v0 = 1'b1;
        exp_q.push_back(val);
      end else begin
        d0 = '0;
        v0 = 1'b0;
      end
      tick();
      if (fixed && i == 3) begin
        check("flow_r4_first", rq(4), 32'h11);
        check("flow_vld_all", stage_vld_o, 4'hF);
        check("flow_stall_cnt", stall_cnt_o, 0);
        check("flow_bubble_cnt", bubble_cnt_o, 0);
      end
      if (stage_vld_o[STAGES-1]) begin
        if (exp_q.size() == 0)
          check("flow_unexpected_out", 1, 0);
        else
          check("flow_r4_data", rq(4), exp_q.pop_front());
      end
    end
    check("flow_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{5'b00000, 5'b00000};
    vecs[1] = '{5'b00001, 5'b00001};
    vecs[2] = '{5'b00010, 5'b00011};
    vecs[3] = '{5'b00100, 5'b00111};
    vecs[4] = '{5'b01000, 5'b01111};
    vecs[5] = '{5'b10000, 5'b11111};
    vecs[6] = '{5'b00101, 5'b00111};
    vecs[7] = '{5'b10001, 5'b11111};
    vecs[8] = '{5'b01010, 5'b01111};
    vecs[9] = '{5'b00110, 5'b00111};

    rst = 1'b0; d0 = '0; v0 = 1'b0;
    stall_req_i = '0; flush_i = '0; cnt_clr_i = 1'b0;
    tick();
    tick();
    check("rst_vld", stage_vld_o, 0);
    check("rst_q", stage_q_o, 0);

    // Stall resolution is combinational, so it is visible while held in reset.
    for (int i = 0; i < 10; i++) begin
      stall_req_i = vecs[i].req;
      #2;
      check($sformatf("stall_vec%0d", i), stall_o, vecs[i].exp_stall);
      check($sformatf("pc_hold_vec%0d", i), pc_hold_o, vecs[i].exp_stall[0]);
    end
    stall_req_i = 5'b00001;
    tick();
    check("rst_cnt_frozen", {stall_cnt_o, bubble_cnt_o}, 0);
    stall_req_i = '0;
    rst = 1'b1;

    run_flow(4, 1'b1);
    run_flow(12, 1'b0);

    // Mid stall at S2.
    feed(32'hA1, 1'b1); feed(32'hA2, 1'b1); feed(32'hA3, 1'b1); feed(32'hA4, 1'b1);
    stall_req_i = 5'b00100;
    d0 = 32'hB1; v0 = 1'b1;
    #1;
    check("mid_stall_o", stall_o, 5'b00111);
    check("mid_pc_hold", pc_hold_o, 1);
    tick();
    check("mid1_r1", rq(1), 32'hA4);
    check("mid1_r2", rq(2), 32'hA3);
    check("mid1_r3", rq(3), 0);
    check("mid1_r4", rq(4), 32'hA2);
    check("mid1_vld", stage_vld_o, 4'b1011);
    tick();
    check("mid2_r4", rq(4), 0);
    check("mid2_vld", stage_vld_o, 4'b0011);
    check("mid2_stall_cnt", stall_cnt_o, 2);
    check("mid2_bubble_cnt", bubble_cnt_o, 2);
    stall_req_i = '0;
    tick();
    check("mid_rel_r1", rq(1), 32'hB1);
    check("mid_rel_r3", rq(3), 32'hA3);
    check("mid_rel_vld", stage_vld_o, 4'b0111);

    // Last-stage stall: everything holds, no bubble.
    stall_req_i = 5'b10000;
    d0 = 32'hB2;
    tick();
    tick();
    check("last_r1", rq(1), 32'hB1);
    check("last_r2", rq(2), 32'hA4);
    check("last_r3", rq(3), 32'hA3);
    check("last_vld", stage_vld_o, 4'b0111);
    check("last_stall_cnt", stall_cnt_o, 4);
    check("last_bubble_cnt", bubble_cnt_o, 2);

    // Flush beats stall, then the flushed registers hold the bubble.
    stall_req_i = 5'b00100;
    flush_i = 4'b0011;
    tick();
    flush_i = '0;
    check("flush1_q123", stage_q_o[3*DATA_W-1:0], 0);
    check("flush1_r4", rq(4), 32'hA3);
    check("flush1_vld", stage_vld_o, 4'b1000);
    tick();
    check("flush2_q", stage_q_o, 0);
    check("flush2_vld", stage_vld_o, 4'b0000);
    check("flush2_stall_cnt", stall_cnt_o, 6);
    check("flush2_bubble_cnt", bubble_cnt_o, 4);

    // Saturation and clear.
    stall_req_i = '0;
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    check("clr_cnts", {stall_cnt_o, bubble_cnt_o}, 0);
    stall_req_i = 5'b00001;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_cnt", stall_cnt_o, 4'hF);
    check("sat_bubble_cnt", bubble_cnt_o, 4'hF);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    check("sat_clr_stall_cnt", stall_cnt_o, 0);
    tick();
    check("sat_after_clr", stall_cnt_o, 1);

    // Reset in the middle of a stall with valid data.
    stall_req_i = '0;
    feed(32'hC1, 1'b1); feed(32'hC2, 1'b1); feed(32'hC3, 1'b1); feed(32'hC4, 1'b1);
    stall_req_i = 5'b00100;
    feed(32'hC5, 1'b1);
    check("pre_rst_vld", stage_vld_o, 4'b1011);
    rst = 1'b0;
    tick();
    check("midrst_vld", stage_vld_o, 0);
    check("midrst_q", stage_q_o, 0);
    check("midrst_cnts", {stall_cnt_o, bubble_cnt_o}, 0);
    rst = 1'b1;
    v0 = 1'b0;
    #1;
    check("midrst_stall_o", stall_o, 5'b00111);
    tick();
    check("midrst_resume_cnt", stall_cnt_o, 1);
    check("midrst_resume_vld", stage_vld_o, 0);
    stall_req_i = '0;
    run_flow(6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
